dmem_lsu: RTL and testbench

Parametrised data-memory load/store unit for the RV32I core: byte-addressable RAM with a valid/ready request port, a configurable number of wait states, RV32I size/sign handling, and misaligned/illegal-size error reporting. It sits between the Exec stage (address = ALU_Out_t, store data = reg_data_2_t, size = funct3) and the register-file write-back mux. It generalises the fixed single-cycle data memory: depth and latency are parameters, and misalignment is detected.

---
 rtl/dmem_lsu.sv | 110 +++++++++++
 tb/tb_dmem_lsu.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressable data RAM with valid/ready requests, parametrised wait states,
// RV32I size/sign handling and misalignment / illegal-size error responses.
module dmem_lsu #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_t,
    input  logic              rst_t,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [2:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         wr_q;
    logic [2:0]   size_q;
    logic [AW+1:0] addr_q;
    logic [31:0]  wdata_q, rdata_q, rdata_d;
    logic         err_q, err_d;
    logic [31:0]  mem [DEPTH_WORDS];
    logic         idle, go_resp, c_wr, illegal, misal;
    logic [2:0]   c_size;
    logic [AW+1:0] c_addr;
    logic [31:0]  c_wdata, word, ld, wd;
    logic [7:0]   b;
    logic [15:0]  h;
    logic [3:0]   be;
    logic         unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_W-1:AW+2];
    assign idle      = state_q == IDLE;
    assign req_ready = idle;
    assign busy      = ~idle;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    // With zero wait states the access happens on the accept edge, so use the live request.
    assign c_wr    = idle ? req_wr : wr_q;
    assign c_size  = idle ? req_size : size_q;
    assign c_addr  = idle ? req_addr[AW+1:0] : addr_q;
    assign c_wdata = idle ? req_wdata : wdata_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = (WAIT_STATES == 0) ? RESP : WAIT;
                cnt_d   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
            end
            WAIT: if (cnt_q == 4'd0) state_d = RESP;
                  else cnt_d = cnt_q - 4'd1;
            default: state_d = IDLE;
        endcase
    end
    assign go_resp = (state_d == RESP) && (state_q != RESP);
    assign word    = mem[c_addr[AW+1:2]];
    assign b       = word[{c_addr[1:0], 3'b000} +: 8];
    assign h       = c_addr[1] ? word[31:16] : word[15:0];
    assign ld      = (c_size[1:0] == 2'b00) ? {{24{~c_size[2] & b[7]}}, b} :
                     (c_size[1:0] == 2'b01) ? {{16{~c_size[2] & h[15]}}, h} : word;
    assign illegal = (c_size == 3'b011) || (c_size[2:1] == 2'b11) || (c_wr && c_size[2]);
    assign misal   = ((c_size[1:0] == 2'b01) && c_addr[0]) ||
                     ((c_size[1:0] == 2'b10) && (c_addr[1:0] != 2'b00));
    assign err_d   = illegal | misal;
    assign rdata_d = (c_wr | err_d) ? 32'd0 : ld;
    assign be      = (c_size[1:0] == 2'b00) ? (4'b0001 << c_addr[1:0]) :
                     (c_size[1:0] == 2'b01) ? (c_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wd      = (c_size[1:0] == 2'b00) ? {4{c_wdata[7:0]}} :
                     (c_size[1:0] == 2'b01) ? {2{c_wdata[15:0]}} : c_wdata;
    always_ff @(posedge clk_t or negedge rst_t) begin
        if (!rst_t) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (idle && req_valid) begin
                wr_q    <= req_wr;
                size_q  <= req_size;
                addr_q  <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
            end
            if (go_resp) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end
    // RAM is deliberately not reset; reset only blocks a commit on the same edge.
    always_ff @(posedge clk_t) begin
        if (go_resp && rst_t && c_wr && !err_d)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[c_addr[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed checks of dmem_lsu with 0, 1 and 3 wait states (instances 0, 1, 2).
module tb_dmem_lsu;
    logic        clk = 1'b0;
    logic [2:0]  rst_n, v, wr, rdy, bsy, rv, er;
    logic [2:0]  sz [3];
    logic [31:0] ad [3];
    logic [31:0] wd [3];
    logic [31:0] rd [3];
    int total = 0, pass = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.DEPTH_WORDS(256), .WAIT_STATES(0), .ADDR_W(32)) u_ws0 (
        .clk_t(clk), .rst_t(rst_n[0]), .req_valid(v[0]), .req_ready(rdy[0]), .req_wr(wr[0]),
        .req_size(sz[0]), .req_addr(ad[0]), .req_wdata(wd[0]), .rsp_valid(rv[0]),
        .rsp_rdata(rd[0]), .rsp_err(er[0]), .busy(bsy[0]));
    dmem_lsu #(.DEPTH_WORDS(256), .WAIT_STATES(1), .ADDR_W(32)) u_ws1 (
        .clk_t(clk), .rst_t(rst_n[1]), .req_valid(v[1]), .req_ready(rdy[1]), .req_wr(wr[1]),
        .req_size(sz[1]), .req_addr(ad[1]), .req_wdata(wd[1]), .rsp_valid(rv[1]),
        .rsp_rdata(rd[1]), .rsp_err(er[1]), .busy(bsy[1]));
    dmem_lsu #(.DEPTH_WORDS(256), .WAIT_STATES(3), .ADDR_W(32)) u_ws3 (
        .clk_t(clk), .rst_t(rst_n[2]), .req_valid(v[2]), .req_ready(rdy[2]), .req_wr(wr[2]),
        .req_size(sz[2]), .req_addr(ad[2]), .req_wdata(wd[2]), .rsp_valid(rv[2]),
        .rsp_rdata(rd[2]), .rsp_err(er[2]), .busy(bsy[2]));

    typedef struct {
        logic        w;
        logic [2:0]  s;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t tv [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // One request on instance k; lat counts falling edges after the accept edge until rsp_valid.
    task automatic xact(input int k, input logic w, input logic [2:0] s, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] r, output logic e, output int lat);
        @(negedge clk);
        v[k] = 1'b1; wr[k] = w; sz[k] = s; ad[k] = a; wd[k] = d;
        @(negedge clk);
        v[k] = 1'b0; wr[k] = ~w; sz[k] = 3'b111; ad[k] = ~a; wd[k] = ~d;
        lat = 0;
        while (!rv[k] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = rd[k];
        e = er[k];
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic        e;
        int          lat, acc, pulses, prev_rv, acc_cyc [3];
        tv[0]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        tv[1]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tv[2]  = '{1'b1, 3'b000, 32'h13,  32'hAAAAAA7F, 32'h0,        1'b0};
        tv[3]  = '{1'b1, 3'b001, 32'h10,  32'h55558001, 32'h0,        1'b0};
        tv[4]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'h7FAD8001, 1'b0};
        tv[5]  = '{1'b0, 3'b000, 32'h11,  32'h0,        32'hFFFFFF80, 1'b0};
        tv[6]  = '{1'b0, 3'b100, 32'h11,  32'h0,        32'h00000080, 1'b0};
        tv[7]  = '{1'b0, 3'b001, 32'h10,  32'h0,        32'hFFFF8001, 1'b0};
        tv[8]  = '{1'b0, 3'b101, 32'h12,  32'h0,        32'h00007FAD, 1'b0};
        tv[9]  = '{1'b0, 3'b000, 32'h13,  32'h0,        32'h0000007F, 1'b0};
        tv[10] = '{1'b0, 3'b001, 32'h12,  32'h0,        32'h00007FAD, 1'b0};
        tv[11] = '{1'b0, 3'b010, 32'h12,  32'h0,        32'h0,        1'b1};
        tv[12] = '{1'b0, 3'b001, 32'h11,  32'h0,        32'h0,        1'b1};
        tv[13] = '{1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1};
        tv[14] = '{1'b1, 3'b010, 32'h11,  32'h11111111, 32'h0,        1'b1};
        tv[15] = '{1'b1, 3'b100, 32'h10,  32'h22222222, 32'h0,        1'b1};
        tv[16] = '{1'b0, 3'b110, 32'h10,  32'h0,        32'h0,        1'b1};
        tv[17] = '{1'b0, 3'b010, 32'h10,  32'h0,        32'h7FAD8001, 1'b0};
        tv[18] = '{1'b1, 3'b010, 32'h400, 32'h12345678, 32'h0,        1'b0};
        tv[19] = '{1'b0, 3'b010, 32'h000, 32'h0,        32'h12345678, 1'b0};

        rst_n = 3'b000; v = '0; wr = '0;
        for (int k = 0; k < 3; k++) begin sz[k] = '0; ad[k] = '0; wd[k] = '0; end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset ready[%0d]", k), 32'(rdy[k]), 32'd1);
            chk($sformatf("reset busy[%0d]", k), 32'(bsy[k]), 32'd0);
            chk($sformatf("reset rsp_valid[%0d]", k), 32'(rv[k]), 32'd0);
            chk($sformatf("reset rdata[%0d]", k), rd[k], 32'd0);
            chk($sformatf("reset err[%0d]", k), 32'(er[k]), 32'd0);
        end
        rst_n = 3'b111;

        for (int i = 0; i < 20; i++) begin
            xact(1, tv[i].w, tv[i].s, tv[i].a, tv[i].d, r, e, lat);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd1);
            chk($sformatf("vec%0d rdata", i), r, tv[i].exp_rd);
            chk($sformatf("vec%0d err", i), 32'(e), 32'(tv[i].exp_err));
            @(negedge clk);
            chk($sformatf("vec%0d single pulse", i), 32'(rv[1]), 32'd0);
            chk($sformatf("vec%0d hold rdata", i), rd[1], tv[i].exp_rd);
        end

        // Zero wait states, req_valid held for three loads.
        xact(0, 1'b1, 3'b010, 32'h4, 32'hA5A5_0F0F, r, e, lat);
        chk("ws0 store latency", 32'(lat), 32'd0);
        @(negedge clk);
        v[0] = 1'b1; wr[0] = 1'b0; sz[0] = 3'b010; ad[0] = 32'h4;
        acc = 0; pulses = 0; prev_rv = 0;
        for (int c = 0; c < 10; c++) begin
            if (rv[0]) begin
                pulses++;
                chk($sformatf("b2b ready low in RESP c%0d", c), 32'(rdy[0]), 32'd0);
                chk($sformatf("b2b rdata c%0d", c), rd[0], 32'hA5A5_0F0F);
                chk($sformatf("b2b no consecutive c%0d", c), 32'(prev_rv), 32'd0);
            end
            prev_rv = int'(rv[0]);
            if (acc == 3) v[0] = 1'b0;
            else if (rdy[0] && v[0]) begin acc_cyc[acc] = c; acc++; end
            @(negedge clk);
        end
        chk("b2b pulse count", 32'(pulses), 32'd3);
        chk("b2b accepts", 32'(acc), 32'd3);
        chk("b2b spacing 1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
        chk("b2b spacing 2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);

        // Three wait states, reset pulsed while a store waits.
        xact(2, 1'b1, 3'b010, 32'h20, 32'h11223344, r, e, lat);
        chk("ws3 store latency", 32'(lat), 32'd3);
        xact(2, 1'b0, 3'b010, 32'h20, 32'h0, r, e, lat);
        chk("ws3 load latency", 32'(lat), 32'd3);
        chk("ws3 load rdata", r, 32'h11223344);
        @(negedge clk);
        v[2] = 1'b1; wr[2] = 1'b1; sz[2] = 3'b010; ad[2] = 32'h20; wd[2] = 32'hCAFEF00D;
        @(negedge clk);
        v[2] = 1'b0;
        chk("abort busy in WAIT", 32'(bsy[2]), 32'd1);
        @(negedge clk);
        rst_n[2] = 1'b0;
        #1;
        chk("abort ready", 32'(rdy[2]), 32'd1);
        chk("abort busy", 32'(bsy[2]), 32'd0);
        chk("abort rsp_valid", 32'(rv[2]), 32'd0);
        chk("abort rdata", rd[2], 32'd0);
        chk("abort err", 32'(er[2]), 32'd0);
        @(negedge clk);
        rst_n[2] = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rv[2]) pulses++;
        end
        chk("abort no response", 32'(pulses), 32'd0);
        xact(2, 1'b0, 3'b010, 32'h20, 32'h0, r, e, lat);
        chk("abort prior contents", r, 32'h11223344);
        chk("abort load err", 32'(e), 32'd0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
